// File: rtl/mtf_decoder.sv
// Move-to-front decoder: turns hit/literal codes back into symbols and keeps a recency list
// in step with the encoder. Define MTF_DEC_FLUSH_EN to add the synchronous flush_in port.
module mtf_decoder #(
  parameter  int WIDTH = 8,
  parameter  int NUM   = 4,
  localparam int IDXW  = $clog2(NUM)
) (
`ifdef MTF_DEC_FLUSH_EN
  input  logic                  flush_in,
`endif
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_hit,
  input  logic [IDXW-1:0]       in_idx,
  input  logic [WIDTH-1:0]      in_literal,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_error,
  output logic [NUM*WIDTH-1:0]  list_out,
  output logic [NUM-1:0]        list_valid,
  output logic [IDXW:0]         fill_out
);

  logic [WIDTH-1:0] entry_q [NUM];
  logic [WIDTH-1:0] entry_d [NUM];
  logic [NUM-1:0]   valid_q, valid_d;
  logic [IDXW:0]    fill_q, fill_d;
  logic             out_valid_q, out_error_q;
  logic [WIDTH-1:0] out_data_q;

  logic             flush;
  logic             accept;
  logic             match_found;
  logic [IDXW-1:0]  match_idx;
  logic             idx_ok;
  logic             move_front;
  logic [IDXW-1:0]  pos;
  logic [WIDTH-1:0] sym;
  logic             code_error;
  logic [WIDTH-1:0] code_data;

`ifdef MTF_DEC_FLUSH_EN
  assign flush = flush_in;
`else
  assign flush = 1'b0;
`endif

  assign in_ready = (!out_valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  // Lowest matching valid entry wins, so a literal never creates a duplicate.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = 0; i < NUM; i++) begin
      if (!match_found && valid_q[i] && (entry_q[i] == in_literal)) begin
        match_found = 1'b1;
        match_idx   = IDXW'(i);
      end
    end
  end

  always_comb begin
    idx_ok = 1'b0;
    if (int'(in_idx) < NUM) idx_ok = valid_q[in_idx];
  end

  assign move_front = in_hit ? idx_ok : match_found;
  assign pos        = in_hit ? in_idx : match_idx;

  always_comb begin
    sym = '0;
    for (int i = 0; i < NUM; i++) begin
      if (IDXW'(i) == pos) sym = entry_q[i];
    end
  end

  assign code_error = in_hit && !idx_ok;
  assign code_data  = code_error ? '0 : (move_front ? sym : in_literal);

  always_comb begin
    entry_d = entry_q;
    valid_d = valid_q;
    fill_d  = fill_q;
    if (flush) begin
      for (int i = 0; i < NUM; i++) entry_d[i] = '0;
      valid_d = '0;
      fill_d  = '0;
    end else if (accept) begin
      if (move_front) begin
        entry_d[0] = sym;
        for (int i = 1; i < NUM; i++) begin
          if (i <= int'(pos)) entry_d[i] = entry_q[i-1];
        end
      end else if (!in_hit) begin
        entry_d[0] = in_literal;
        for (int i = 1; i < NUM; i++) entry_d[i] = entry_q[i-1];
        valid_d = {valid_q[NUM-2:0], 1'b1};
        if (fill_q != (IDXW+1)'(NUM)) fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < NUM; i++) entry_q[i] <= '0;
      valid_q     <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_error_q <= 1'b0;
    end else begin
      entry_q <= entry_d;
      valid_q <= valid_d;
      fill_q  <= fill_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= code_data;
        out_error_q <= code_error;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    list_out = '0;
    for (int i = 0; i < NUM; i++) list_out[i*WIDTH +: WIDTH] = entry_q[i];
  end

  assign list_valid = valid_q;
  assign fill_out   = fill_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_error  = out_error_q;

endmodule
